// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg : md_op encoding and FSM state shared by the md unit and decoder
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package md_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;
   localparam logic [2:0] MD_MTHI  = 3'd5;
   localparam logic [2:0] MD_MTLO  = 3'd6;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } md_state_e;

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ----------------------------------------------------------------------------
// md_arith : combinational 32x32 multiply / divide, {hi,lo} packed as [63:0]
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module md_arith
   import md_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div_zero_o
);

   logic [63:0] w_smul;
   logic [63:0] w_umul;
   logic        w_bz;
   logic [31:0] w_bsafe;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_mq;
   logic [31:0] w_mr;
   logic [31:0] w_sq;
   logic [31:0] w_sr;
   logic [31:0] w_uq;
   logic [31:0] w_ur;

   assign w_smul = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign w_umul = {32'd0, a_i} * {32'd0, b_i};

   // Divisor forced to 1 on zero so the dividers never produce X.
   assign w_bz    = (b_i == 32'd0);
   assign w_bsafe = w_bz ? 32'd1 : b_i;

   // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
   assign w_abs_a = a_i[31] ? (32'd0 - a_i) : a_i;
   assign w_abs_b = w_bsafe[31] ? (32'd0 - w_bsafe) : w_bsafe;
   assign w_mq    = w_abs_a / w_abs_b;
   assign w_mr    = w_abs_a % w_abs_b;
   assign w_sq    = (a_i[31] ^ w_bsafe[31]) ? (32'd0 - w_mq) : w_mq;
   assign w_sr    = a_i[31] ? (32'd0 - w_mr) : w_mr;

   assign w_uq = a_i / w_bsafe;
   assign w_ur = a_i % w_bsafe;

   always_comb begin
      res_o      = 64'd0;
      div_zero_o = 1'b0;
      case (op_i)
         MD_MULT:  res_o = w_smul;
         MD_MULTU: res_o = w_umul;
         MD_DIV: begin
            res_o      = {w_sr, w_sq};
            div_zero_o = w_bz;
         end
         MD_DIVU: begin
            res_o      = {w_ur, w_uq};
            div_zero_o = w_bz;
         end
         default: res_o = 64'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/e_md_unit.sv
// ----------------------------------------------------------------------------
// e_md_unit : E-stage multiply/divide unit with HI/LO and latency countdown
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module e_md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_a,
   input  logic [31:0] md_b,
   output logic        busy,
   output logic        start,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [63:0]      res_q;
   logic             dz_q;
   logic             busy_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;

   logic [63:0] w_res;
   logic        w_dz;
   logic        w_is_md;
   logic        w_is_div;

   md_arith u_arith (
      .op_i       (md_op),
      .a_i        (md_a),
      .b_i        (md_b),
      .res_o      (w_res),
      .div_zero_o (w_dz)
   );

   assign w_is_md  = (md_op >= MD_MULT) && (md_op <= MD_DIVU);
   assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
   // Gated by reset so the hazard unit never sees a start while held in reset.
   assign start    = reset && (state_q == S_IDLE) && w_is_md;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  res_q   <= w_res;
                  dz_q    <= w_dz;
                  cnt_q   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else if (md_op == MD_MTHI) begin
                  hi_q <= md_a;
               end else if (md_op == MD_MTLO) begin
                  lo_q <= md_a;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  if (!dz_q) begin
                     hi_q <= res_q[63:32];
                     lo_q <= res_q[31:0];
                  end
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_e_md_unit.sv
// ----------------------------------------------------------------------------
// tb_e_md_unit : scoreboard bench for e_md_unit, directed vectors
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_e_md_unit;
   import md_pkg::*;

   logic        clk;
   logic        reset;
   logic [2:0]  md_op;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        busy;
   logic        start;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec;
   int   n_bad;
   int   n_illegal;

   e_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md_op (md_op),
      .md_a  (md_a),
      .md_b  (md_b),
      .busy  (busy),
      .start (start),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Protocol checker: a nonzero md_op while busy must never be issued.
   always @(posedge clk) begin
      if (reset && busy && md_op != MD_NONE && md_op != 3'd7) begin
         n_illegal++;
         $display("note: md_op %0d issued while busy at %0t (ignored by unit)", md_op, $time);
      end
   end

   // Monitor: on each busy falling edge pop the oldest expectation.
   logic prev_busy;
   int   bcnt;
   always @(negedge clk) begin
      if (!reset) begin
         prev_busy = 1'b0;
         bcnt      = 0;
      end else begin
         if (busy) begin
            bcnt++;
         end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_commit", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("busy_cycles", 32'(bcnt), 32'(e.cyc));
            end
            bcnt = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_start);
      @(negedge clk);
      md_op = op;
      md_a  = a;
      md_b  = b;
      #1;
      chk("start", {31'd0, start}, {31'd0, exp_start});
      @(negedge clk);
      md_op = MD_NONE;
   endtask

   task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input int cyc);
      exp_t e;
      e.hi = h;
      e.lo = l;
      e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      n_illegal = 0;
      reset = 1'b0;
      md_op = MD_NONE;
      md_a  = '0;
      md_b  = '0;
      repeat (2) @(negedge clk);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b1;

      expect_res(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
      wait_idle();
      expect_res(32'h00000002, 32'hFFFFFFFA, 5);
      issue(MD_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1);
      wait_idle();
      expect_res(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
      wait_idle();
      expect_res(32'd1, 32'd3, 10);
      issue(MD_DIVU, 32'd7, 32'd2, 1'b1);
      wait_idle();

      issue(MD_MTHI, 32'h1234, 32'd0, 1'b0);
      chk("mthi_hi", hi, 32'h1234);
      expect_res(32'h1234, 32'd3, 10);
      issue(MD_DIV, 32'd7, 32'd0, 1'b1);
      wait_idle();
      expect_res(32'd0, 32'h80000000, 10);
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
      wait_idle();

      expect_res(32'd1, 32'd0, 5);
      issue(MD_MULT, 32'h00010000, 32'h00010000, 1'b1);
      issue(MD_MTLO, 32'h5555, 32'd0, 1'b0);
      wait_idle();
      chk("illegal_flagged", 32'(n_illegal), 32'd1);

      @(negedge clk);
      md_op = MD_MTLO;
      md_a  = 32'hABCD;
      #1;
      chk("mtlo_start", {31'd0, start}, 32'd0);
      @(negedge clk);
      md_op = MD_NONE;
      chk("mtlo_lo", lo, 32'hABCD);
      chk("mtlo_hi", hi, 32'd1);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);

      issue(MD_MULT, 32'd5, 32'd6, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      md_op = MD_MULT;
      reset = 1'b0;
      #1;
      chk("async_rst_hi", hi, 32'd0);
      chk("async_rst_lo", lo, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      chk("async_rst_start", {31'd0, start}, 32'd0);
      @(negedge clk);
      md_op = MD_NONE;
      @(negedge clk);
      reset = 1'b1;

      expect_res(32'd0, 32'd30, 5);
      issue(MD_MULT, 32'd5, 32'd6, 1'b1);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
